// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with input FIFO and valid/ready handshake
module uart_tx_param #(
   parameter int CLK_FREQ   = 12000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_BITS-1:0]          data_in,
   input  logic                          data_valid,
   output logic                          data_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam int CW  = 4;
   localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
   localparam logic          PAR_ODD   = (PARITY == 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state, state_nxt;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [LW-1:0]        count;
   logic                 fifo_empty, push, pop;
   logic [BW-1:0]        baud_cnt;
   logic [CW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit, tx_nxt, tick;

   assign fifo_empty = (count == '0);
   assign data_ready = (count != LW'(FIFO_DEPTH));
   assign push       = data_valid & data_ready;
   assign fifo_level = count;
   assign tick       = (baud_cnt == BAUD_LAST);
   assign busy       = (state != S_IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (!fifo_empty) state_nxt = S_START;
         S_START:  if (tick) state_nxt = S_DATA;
         S_DATA:   if (tick && bit_cnt == DATA_LAST) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (tick) state_nxt = S_STOP;
         S_STOP:   if (tick && bit_cnt == STOP_LAST) state_nxt = fifo_empty ? S_IDLE : S_START;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Popping on the last stop clock keeps queued frames back-to-back.
   always_comb begin
      tx_nxt = 1'b1;
      pop    = 1'b0;
      case (state)
         S_IDLE:   pop    = !fifo_empty;
         S_START:  tx_nxt = 1'b0;
         S_DATA:   tx_nxt = shreg[0];
         S_PARITY: tx_nxt = par_bit;
         S_STOP:   pop    = tick && (bit_cnt == STOP_LAST) && !fifo_empty;
         default:  tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx       <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
      end else begin
         tx <= tx_nxt;
         if (state == S_IDLE || tick) baud_cnt <= '0;
         else                         baud_cnt <= baud_cnt + BW'(1);
         if (tick && (state == S_DATA || state == S_STOP))
            bit_cnt <= (state_nxt != state) ? '0 : bit_cnt + CW'(1);
         if (pop) begin
            shreg   <= mem[rd_ptr];
            par_bit <= (^mem[rd_ptr]) ^ PAR_ODD;
         end else if (state == S_DATA && tick) begin
            shreg <= shreg >> 1;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - self-checking bench for uart_tx_param over four frame formats
module tb_uart_tx_param;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din [4];
   logic       vld [4];
   logic       rdy_w [4];
   logic       tx_w [4];
   logic       bsy_w [4];
   logic [2:0] lvl_w [4];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   int p_div   [4] = '{104, 104, 104, 1250};
   int p_dbits [4] = '{8, 8, 8, 7};
   int p_par   [4] = '{0, 2, 1, 0};
   int p_stop  [4] = '{1, 1, 1, 2};

   typedef struct {
      int         inst;
      logic [7:0] word;
      int         len;
      logic       par;
   } vec_t;
   vec_t tbl [7];

   bit         mdl_bits[$];
   logic [7:0] exp_q[$];
   int         starts[$];
   int         rx_count = 0;
   bit         mon_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_param u_def (.clk(clk), .reset(rst_n), .data_in(din[0]), .data_valid(vld[0]),
      .data_ready(rdy_w[0]), .tx(tx_w[0]), .busy(bsy_w[0]), .fifo_level(lvl_w[0]));
   uart_tx_param #(.PARITY(2)) u_even (.clk(clk), .reset(rst_n), .data_in(din[1]), .data_valid(vld[1]),
      .data_ready(rdy_w[1]), .tx(tx_w[1]), .busy(bsy_w[1]), .fifo_level(lvl_w[1]));
   uart_tx_param #(.PARITY(1)) u_odd (.clk(clk), .reset(rst_n), .data_in(din[2]), .data_valid(vld[2]),
      .data_ready(rdy_w[2]), .tx(tx_w[2]), .busy(bsy_w[2]), .fifo_level(lvl_w[2]));
   uart_tx_param #(.BAUD(9600), .DATA_BITS(7), .STOP_BITS(2)) u_7s2 (.clk(clk), .reset(rst_n),
      .data_in(din[3][6:0]), .data_valid(vld[3]), .data_ready(rdy_w[3]), .tx(tx_w[3]),
      .busy(bsy_w[3]), .fifo_level(lvl_w[3]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected line levels of one frame, one entry per bit period.
   function automatic void build_frame(input int inst, input logic [7:0] w);
      int ones;
      mdl_bits.delete();
      mdl_bits.push_back(1'b0);
      ones = 0;
      for (int i = 0; i < p_dbits[inst]; i++) begin
         mdl_bits.push_back(w[i]);
         ones += int'(w[i]);
      end
      if (p_par[inst] == 2) mdl_bits.push_back(ones % 2 == 1);
      if (p_par[inst] == 1) mdl_bits.push_back(ones % 2 == 0);
      for (int i = 0; i < p_stop[inst]; i++) mdl_bits.push_back(1'b1);
   endfunction

   task automatic run_frame(input int inst, input logic [7:0] w, input int len, input logic par_exp);
      int div, errs, ppos;
      logic smp;
      div = p_div[inst];
      build_frame(inst, w);
      chk("ready_before_push", rdy_w[inst], 1);
      din[inst] = w;
      vld[inst] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vld[inst] = 1'b0;
      chk("accept_level", lvl_w[inst], 1);
      chk("accept_busy", bsy_w[inst], 1);
      @(negedge clk);
      chk("pop_level", lvl_w[inst], 0);
      @(negedge clk);
      chk("start_latency", tx_w[inst], 0);
      ppos = (1 + p_dbits[inst]) * div + div / 2;
      errs = 0;
      for (int s = 0; s < len; s++) begin
         if (s > 0) @(negedge clk);
         smp = tx_w[inst];
         if (s / div >= mdl_bits.size() || smp !== mdl_bits[s / div]) errs++;
         if (s % div == div - 1) begin
            chk($sformatf("inst%0d_bit%0d_bad_clocks", inst, s / div), errs, 0);
            errs = 0;
         end
         if (p_par[inst] != 0 && s == ppos) chk("parity_bit", smp, par_exp);
         if (s == len - 2) chk("busy_in_frame", bsy_w[inst], 1);
         if (s == len - 1) chk("busy_after_frame", bsy_w[inst], 0);
      end
   endtask

   task automatic push_wait(input int inst, input logic [7:0] w, output int acc_cyc);
      bit rdy, acc;
      int t;
      din[inst] = w;
      vld[inst] = 1'b1;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 5000) begin
         rdy = rdy_w[inst];
         @(posedge clk);
         acc = rdy;
         @(negedge clk);
         t++;
      end
      chk("accept_within_bound", acc, 1);
      acc_cyc = cyc;
   endtask

   task automatic wait_idle(input int bound, output int fall_cyc);
      int t;
      t = 0;
      while (bsy_w[0] && t < bound) begin
         @(negedge clk);
         t++;
      end
      chk("drain_within_bound", t < bound, 1);
      fall_cyc = cyc;
   endtask

   // Receiver for the default instance: samples each bit at its centre.
   initial begin : rx_mon
      logic [7:0] rw;
      forever begin
         @(negedge clk);
         if (mon_en && tx_w[0] === 1'b0) begin
            starts.push_back(cyc);
            repeat (52) @(negedge clk);
            chk("rx_start_bit", tx_w[0], 0);
            rw = '0;
            for (int i = 0; i < 8; i++) begin
               repeat (104) @(negedge clk);
               rw[i] = tx_w[0];
            end
            repeat (104) @(negedge clk);
            chk("rx_stop_bit", tx_w[0], 1);
            chk("rx_frame_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("rx_word", rw, exp_q.pop_front());
            rx_count++;
            repeat (51) @(negedge clk);
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      miscompares++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "timeout");
   end

   initial begin : main
      int acc [7];
      int fall, dummy;
      logic [7:0] w;
      tbl[0] = '{0, 8'h55, 1040, 1'b0};
      tbl[1] = '{1, 8'h07, 1144, 1'b1};
      tbl[2] = '{2, 8'h07, 1144, 1'b0};
      tbl[3] = '{1, 8'h00, 1144, 1'b0};
      tbl[4] = '{2, 8'h00, 1144, 1'b1};
      tbl[5] = '{0, 8'hFF, 1040, 1'b0};
      tbl[6] = '{3, 8'h41, 12500, 1'b0};

      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         din[i] = '0;
         vld[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) chk($sformatf("reset_tx%0d", i), tx_w[i], 1);
      chk("reset_busy", bsy_w[0], 0);
      chk("reset_ready", rdy_w[0], 1);
      chk("reset_level", lvl_w[0], 0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         run_frame(tbl[i].inst, tbl[i].word, tbl[i].len, tbl[i].par);
         repeat (3) @(negedge clk);
      end

      mon_en = 1'b1;
      starts.delete();
      rx_count = 0;
      for (int k = 0; k < 8; k++) begin
         repeat ($urandom_range(0, 600)) @(negedge clk);
         w = 8'($urandom_range(0, 255));
         exp_q.push_back(w);
         push_wait(0, w, dummy);
         vld[0] = 1'b0;
      end
      wait_idle(20000, fall);
      repeat (5) @(negedge clk);
      chk("rand_frames", rx_count, 8);
      chk("rand_leftover", exp_q.size(), 0);

      starts.delete();
      rx_count = 0;
      for (int k = 1; k <= 6; k++) exp_q.push_back(8'(k));
      for (int k = 1; k <= 6; k++) begin
         push_wait(0, 8'(k), acc[k]);
         if (k == 5) begin
            chk("full_ready_low", rdy_w[0], 0);
            chk("full_level", lvl_w[0], 4);
            chk("burst_accepts", acc[5] - acc[1], 4);
         end
      end
      vld[0] = 1'b0;
      chk("sixth_accept", acc[6] - acc[1], 1042);
      wait_idle(10000, fall);
      repeat (5) @(negedge clk);
      chk("b2b_frames", rx_count, 6);
      chk("b2b_starts", starts.size(), 6);
      if (starts.size() == 6) begin
         for (int k = 1; k < 6; k++) chk($sformatf("b2b_gap%0d", k), starts[k] - starts[k-1], 1040);
         chk("b2b_busy_fall", fall - starts[0], 6239);
      end
      mon_en = 1'b0;

      @(negedge clk);
      for (int k = 0; k < 4; k++) push_wait(0, 8'h00, acc[k]);
      vld[0] = 1'b0;
      chk("queued_level", lvl_w[0], 3);
      repeat (300) @(negedge clk);
      chk("mid_data_tx", tx_w[0], 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_tx", tx_w[0], 1);
      chk("async_reset_level", lvl_w[0], 0);
      chk("async_reset_busy", bsy_w[0], 0);
      chk("async_reset_ready", rdy_w[0], 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      run_frame(0, 8'hA5, 1040, 1'b0);
      repeat (3) @(negedge clk);
      chk("final_idle_tx", tx_w[0], 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with a small input FIFO and valid/ready handshake, generalising the fixed-format serial output path used by the clock/status streamers. Frame format (data width, parity, stop bits) and baud rate are set by parameters, and bytes queued in the FIFO are sent back-to-back with no idle gap. It sits between any byte-producing client (formatters, debug streamers) and the board `tx` pin, on the 12 MHz system clock.

## Interface
- `CLK_FREQ`, 12000000, system clock frequency in Hz.
- `BAUD`, 115200, line rate in bit/s.
- `DATA_BITS`, 8, payload bits per frame; legal range 5..9.
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1, stop bits per frame: 1 or 2.
- `FIFO_DEPTH`, 4, input FIFO entries; power of 2, at least 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in`  in  DATA_BITS  word to send; sampled when `data_valid` and `data_ready` are both high.
- `data_valid`  in  1  client has a word.
- `data_ready`  out  1  FIFO not full; equals `~full`, driven from registers only.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high when the FIFO is non-empty or a frame is in progress.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of queued words, not counting the word being shifted.

## Operation
- Bit period: DIV = (CLK_FREQ + BAUD/2) / BAUD, rounded to nearest; an integer baud counter of width $clog2(DIV) counts 0..DIV-1. Defaults give DIV = 104.
- Frame, LSB first: start (0), DATA_BITS data bits, optional parity, STOP_BITS stops (1). Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × DIV clocks.
- Parity bit: odd mode makes the total count of ones in data plus parity odd; even mode makes it even.
- FSM states:
  - IDLE: `tx` = 1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx` = 0 for DIV clocks, then go to DATA.
  - DATA: shift out DATA_BITS bits, each for DIV clocks. Then go to PARITY, or to STOP when PARITY = 0.
  - PARITY: send the parity bit for DIV clocks, then go to STOP.
  - STOP: `tx` = 1 for STOP_BITS × DIV clocks. On the last clock, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- `tx` is driven from a register and never glitches.
- FIFO:
  - A push on a handshake and a pop in the same cycle are both performed; `fifo_level` stays unchanged.
  - No push is possible when full, because `data_ready` is low.
  - A pop is only taken when the FIFO is registered non-empty, so the FIFO never underflows.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (asynchronous, at any time, including mid-frame):
  - `tx` = 1, `busy` = 0, `data_ready` = 1, `fifo_level` = 0.
  - FSM returns to IDLE; counters, pointers and the shift register are cleared.
  - Any partial frame is truncated, and queued words are discarded.
- Reset release is synchronous to `clk`. The first handshake can be accepted on the first edge after release.

## Timing
- Handshake at edge N into an empty, idle block:
  - Edge N: word written; `fifo_level` = 1, `busy` = 1.
  - Edge N+1: IDLE pops; `fifo_level` = 0.
  - Edge N+2: `tx` falls.
- Each bit holds for exactly DIV clocks. The stop-to-start transition between queued words is seamless.
- `busy` falls on the same edge at which STOP returns to IDLE.
- `data_ready` rises on the edge after a pop frees a full FIFO.

## Test plan
- Defaults, push 0x55 once → `tx` high, then 104 clocks at 0, bits 1,0,1,0,1,0,1,0 at 104 clocks each, stop high for 104 clocks. Total frame 1040 clocks; `busy` then falls.
- PARITY=2, push 0x07 → parity bit 1; PARITY=1, push 0x07 → parity bit 0. Frame is 1144 clocks in both cases.
- Defaults, `data_valid` held high for 6 consecutive cycles with words 0x01..0x06 → 5 words accepted. `data_ready` goes low after the 5th accept with `fifo_level` = 4; 0x06 is accepted after the first frame ends. All 6 frames go out back-to-back over 6240 clocks with no idle gap.
- STOP_BITS=2, DATA_BITS=7, BAUD=9600 (DIV = 1250), push 0x41 → stop-high period of 2500 clocks; frame 12500 clocks.
- Reset asserted mid-DATA with 3 words queued → `tx` = 1 immediately (asynchronously), `fifo_level` = 0, `busy` = 0. After release, a new push of 0xA5 is transmitted correctly with handshake-to-`tx`-fall latency of 2 clocks.
